// File: rtl/famicom_pkg.sv
// Shared types and default timing constants for the Famicom/NES pad reader.
package famicom_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } famicom_state_e;

  localparam int unsigned FAMICOM_HALF_PERIOD    = 6;
  localparam int unsigned FAMICOM_LATCH_CYCLES   = 12;
  localparam int unsigned FAMICOM_POLL_60HZ_100M = 1666667;
  localparam int unsigned FAMICOM_NUM_BITS       = 8;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int unsigned famicom_width_for(input int unsigned v);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < v) begin
      w = w + 1;
    end
    return w;
  endfunction

  function automatic int unsigned famicom_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/famicom_phase_timer.sv
// Loadable down-counter that times the latch, pulse-low and pulse-high phases.
module famicom_phase_timer
  import famicom_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] value_o,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A phase loaded with N-1 reports done in its N-th cycle.
  assign value_o = count_q;
  assign done_o  = (count_q == '0);

endmodule

// File: rtl/famicom_pad_reader.sv
// Initiator side of the Famicom serial pad protocol: drives latch/pulse,
// shifts in the pad bits and presents an active-high button byte with a strobe.
module famicom_pad_reader
  import famicom_pkg::*;
#(
  parameter int unsigned HALF_PERIOD   = FAMICOM_HALF_PERIOD,
  parameter int unsigned LATCH_CYCLES  = FAMICOM_LATCH_CYCLES,
  parameter int unsigned POLL_INTERVAL = FAMICOM_POLL_60HZ_100M,
  parameter int unsigned NUM_BITS      = FAMICOM_NUM_BITS
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                enable,
  input  logic                famicom_data,
  output logic                famicom_latch,
  output logic                famicom_pulse,
  output logic [NUM_BITS-1:0] buttons,
  output logic                buttons_valid,
  output logic                busy
);

  localparam int unsigned TIMER_W = famicom_width_for(famicom_max(LATCH_CYCLES, HALF_PERIOD));
  localparam int unsigned IDX_W   = famicom_width_for(NUM_BITS);

  localparam logic [TIMER_W-1:0] LATCH_LOAD = TIMER_W'(LATCH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HALF_LOAD  = TIMER_W'(HALF_PERIOD - 1);
  localparam logic [31:0]        POLL_LOAD  = 32'(POLL_INTERVAL - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_BITS - 1);

  famicom_state_e      state_q, state_d;
  logic                latch_q, latch_d;
  logic                pulse_q, pulse_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [NUM_BITS-1:0] buttons_q, buttons_d;
  logic                valid_q, valid_d;
  logic [31:0]         poll_q, poll_d;
  logic                data_meta_q, data_sync_q;

  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_load_value;
  logic [TIMER_W-1:0]  tmr_value;
  logic                tmr_done;
  logic                sample_now;

  famicom_phase_timer #(
    .WIDTH (TIMER_W)
  ) u_phase_timer (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .load_i       (tmr_load),
    .load_value_i (tmr_load_value),
    .value_o      (tmr_value),
    .done_o       (tmr_done)
  );

  // Idle level of the data line is high (not pressed).
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      data_meta_q <= famicom_data;
      data_sync_q <= data_meta_q;
    end
  end

  assign sample_now = (state_q == LOW) && (tmr_value == '0);

  always_comb begin
    state_d        = state_q;
    latch_d        = latch_q;
    pulse_d        = pulse_q;
    idx_d          = idx_q;
    shift_d        = shift_q;
    buttons_d      = buttons_q;
    valid_d        = 1'b0;
    poll_d         = (poll_q != '0) ? (poll_q - 32'd1) : '0;
    tmr_load       = 1'b0;
    tmr_load_value = '0;

    case (state_q)
      IDLE: begin
        if (enable && (poll_q == '0)) begin
          state_d        = LATCH;
          latch_d        = 1'b1;
          shift_d        = '0;
          poll_d         = POLL_LOAD;
          tmr_load       = 1'b1;
          tmr_load_value = LATCH_LOAD;
        end
      end
      LATCH: begin
        if (tmr_done) begin
          state_d        = LOW;
          latch_d        = 1'b0;
          idx_d          = '0;
          tmr_load       = 1'b1;
          tmr_load_value = HALF_LOAD;
        end
      end
      LOW: begin
        if (sample_now) begin
          shift_d[idx_q] = data_sync_q;
        end
        if (tmr_done) begin
          if (idx_q == LAST_IDX) begin
            // Buttons and strobe land together in the DONE cycle.
            state_d   = DONE;
            buttons_d = ~shift_d;
            valid_d   = 1'b1;
          end else begin
            state_d        = HIGH;
            pulse_d        = 1'b1;
            tmr_load       = 1'b1;
            tmr_load_value = HALF_LOAD;
          end
        end
      end
      HIGH: begin
        if (tmr_done) begin
          state_d        = LOW;
          pulse_d        = 1'b0;
          idx_d          = idx_q + 1'b1;
          tmr_load       = 1'b1;
          tmr_load_value = HALF_LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        latch_d = 1'b0;
        pulse_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      idx_q     <= '0;
      shift_q   <= '0;
      buttons_q <= '0;
      valid_q   <= 1'b0;
      poll_q    <= '0;
    end else begin
      state_q   <= state_d;
      latch_q   <= latch_d;
      pulse_q   <= pulse_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      poll_q    <= poll_d;
    end
  end

  assign famicom_latch = latch_q;
  assign famicom_pulse = pulse_q;
  assign buttons       = buttons_q;
  assign buttons_valid = valid_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_famicom_pad_reader.sv
// Bench for famicom_pad_reader: behavioural pad models, expected-button queue
// and protocol timing monitors on two instances (200- and 50-cycle poll).
module tb_famicom_pad_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, enable_a, data_a, latch_a, pulse_a, valid_a, busy_a;
  logic [7:0] buttons_a;
  logic       reset_b, enable_b, data_b, latch_b, pulse_b, valid_b, busy_b;
  logic [7:0] buttons_b;

  famicom_pad_reader #(
    .HALF_PERIOD   (6),
    .LATCH_CYCLES  (12),
    .POLL_INTERVAL (200),
    .NUM_BITS      (8)
  ) dut_a (
    .clk_sys       (clk),
    .reset         (reset_a),
    .enable        (enable_a),
    .famicom_data  (data_a),
    .famicom_latch (latch_a),
    .famicom_pulse (pulse_a),
    .buttons       (buttons_a),
    .buttons_valid (valid_a),
    .busy          (busy_a)
  );

  famicom_pad_reader #(
    .HALF_PERIOD   (6),
    .LATCH_CYCLES  (12),
    .POLL_INTERVAL (50),
    .NUM_BITS      (8)
  ) dut_b (
    .clk_sys       (clk),
    .reset         (reset_b),
    .enable        (enable_b),
    .famicom_data  (data_b),
    .famicom_latch (latch_b),
    .famicom_pulse (pulse_b),
    .buttons       (buttons_b),
    .buttons_valid (valid_b),
    .busy          (busy_b)
  );

  // Pad: parallel load while latch is high, shift toward bit 0 on pulse rise.
  logic [7:0] raw_a, raw_b;
  logic [7:0] sr_a = 8'hFF;
  logic [7:0] sr_b = 8'hFF;
  logic       pp_a = 1'b0;
  logic       pp_b = 1'b0;
  always @(posedge clk) begin
    pp_a <= pulse_a;
    pp_b <= pulse_b;
    if (latch_a) sr_a <= raw_a;
    else if (pulse_a && !pp_a) sr_a <= {1'b1, sr_a[7:1]};
    if (latch_b) sr_b <= raw_b;
    else if (pulse_b && !pp_b) sr_b <= {1'b1, sr_b[7:1]};
  end
  assign data_a = sr_a[0];
  assign data_b = sr_b[0];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor state, instance A
  int   rise_a = 0, prev_rise_a = 0, frames_a = 0, valids_a = 0;
  int   latch_len_a = 0, pulse_rises_a = 0, overlap_a = 0, lo_run_a = 0, hi_run_a = 0;
  logic pl_a = 1'b0, ppm_a = 1'b0;
  bit   period_chk = 1'b0;
  // Monitor state, instance B
  int   rise_b = 0, vcyc_b = 0, valids_b = 0, overlap_b = 0;
  logic pl_b = 1'b0;
  bit   have_v_b = 1'b0;
  logic [7:0] exp_pop;

  always @(negedge clk) begin
    if (reset_a) begin
      pl_a  = 1'b0;
      ppm_a = 1'b0;
    end else begin
      if (latch_a && !pl_a) begin
        if (period_chk) check("latch_period", cyc - rise_a, 200);
        prev_rise_a   = rise_a;
        rise_a        = cyc;
        latch_len_a   = 0;
        pulse_rises_a = 0;
        overlap_a     = 0;
        frames_a++;
      end
      if (latch_a && pulse_a) overlap_a++;
      if (latch_a) latch_len_a++;
      if (!latch_a && pl_a) lo_run_a = 0;
      if (pulse_a && !ppm_a) begin
        pulse_rises_a++;
        check("pulse_low_len", lo_run_a, 6);
        hi_run_a = 0;
      end
      if (!pulse_a && ppm_a) begin
        check("pulse_high_len", hi_run_a, 6);
        lo_run_a = 0;
      end
      if (pulse_a) hi_run_a++;
      else lo_run_a++;
      if (valid_a) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_pop = exp_q.pop_front();
          check("buttons", buttons_a, exp_pop);
          check("valid_cycle", cyc - rise_a, 102);
          check("latch_len", latch_len_a, 12);
          check("pulse_rises", pulse_rises_a, 7);
          check("latch_pulse_overlap", overlap_a, 0);
          check("busy_at_valid", busy_a, 1);
        end
        valids_a++;
      end
      pl_a  = latch_a;
      ppm_a = pulse_a;
    end

    if (reset_b) begin
      pl_b     = 1'b0;
      have_v_b = 1'b0;
    end else begin
      if (latch_b && pulse_b) overlap_b++;
      if (latch_b && !pl_b) begin
        if (have_v_b) check("b_valid_to_latch", cyc - vcyc_b, 2);
        rise_b = cyc;
      end
      if (valid_b) begin
        check("b_buttons", buttons_b, 8'hC3);
        check("b_valid_cycle", cyc - rise_b, 102);
        check("b_busy_at_valid", busy_b, 1);
        vcyc_b   = cyc;
        have_v_b = 1'b1;
        valids_b++;
      end
      pl_b = latch_b;
    end
  end

  task automatic wait_valid_a(input int budget, input string name);
    int  v0;
    bit  got;
    v0  = valids_a;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(posedge clk); #1;
      if (valids_a != v0) got = 1'b1;
    end
    if (!got) check(name, 0, 1);
  endtask

  task automatic wait_frame_a(input int budget, input string name);
    int  f0;
    bit  got;
    f0  = frames_a;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(posedge clk); #1;
      if (frames_a != f0) got = 1'b1;
    end
    if (!got) check(name, 0, 1);
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [7:0] raw;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    int v0, f1, t, r0;
    vecs[0] = '{raw: 8'b1111_1110, exp: 8'h01};
    vecs[1] = '{raw: 8'h5A,        exp: 8'hA5};
    vecs[2] = '{raw: 8'hFF,        exp: 8'h00};
    vecs[3] = '{raw: 8'h00,        exp: 8'hFF};
    vecs[4] = '{raw: 8'h7F,        exp: 8'h80};

    reset_a = 1'b1; reset_b = 1'b1;
    enable_a = 1'b0; enable_b = 1'b0;
    raw_a = 8'hFF; raw_b = 8'h3C;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_latch", latch_a, 0);
    check("rst_pulse", pulse_a, 0);
    check("rst_buttons", buttons_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    @(posedge clk); #1;
    reset_a = 1'b0; reset_b = 1'b0;

    for (int i = 0; i < 5; i++) begin
      raw_a = vecs[i].raw;
      exp_q.push_back(vecs[i].exp);
      enable_a = 1'b1;
      wait_valid_a(500, "vec_valid_timeout");
      enable_a = 1'b0;
    end

    // enable dropped mid-frame: frame completes, nothing new starts
    raw_a = 8'hA3;
    exp_q.push_back(8'h5C);
    enable_a = 1'b1;
    wait_frame_a(300, "drop_frame_timeout");
    wait_cycle(rise_a + 40);
    enable_a = 1'b0;
    wait_valid_a(200, "drop_valid_timeout");
    f1 = frames_a;
    repeat (300) @(posedge clk);
    #1;
    check("no_latch_while_disabled", frames_a, f1);
    check("buttons_hold", buttons_a, 8'h5C);

    // re-enable with counter expired; this frame is then aborted by reset
    raw_a = 8'hC6;
    t = cyc;
    enable_a = 1'b1;
    wait_frame_a(10, "reenable_timeout");
    check("reenable_latency", rise_a - t, 1);
    r0 = rise_a;
    wait_cycle(r0 + 50);
    v0 = valids_a;
    reset_a = 1'b1;
    @(posedge clk); #1;
    reset_a = 1'b0;
    raw_a = 8'h96;
    exp_q.push_back(8'h69);
    @(negedge clk);
    check("abort_latch", latch_a, 0);
    check("abort_pulse", pulse_a, 0);
    check("abort_buttons", buttons_a, 0);
    check("abort_valid", valid_a, 0);
    wait_frame_a(10, "restart_timeout");
    check("restart_cycle", rise_a - r0, 52);
    check("no_valid_after_abort", valids_a, v0);

    // continuous polling, pad value changes between frames
    period_chk = 1'b1;
    wait_valid_a(300, "cont_valid_timeout");
    raw_a = 8'h0F;
    exp_q.push_back(8'hF0);
    wait_valid_a(300, "cont_valid_timeout");
    raw_a = 8'hE7;
    exp_q.push_back(8'h18);
    wait_valid_a(300, "cont_valid_timeout");
    enable_a = 1'b0;
    period_chk = 1'b0;

    // back-to-back frames with a poll interval shorter than a frame
    enable_b = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int k = 0; k < 1000 && !got; k++) begin
        @(posedge clk); #1;
        if (valids_b >= 3) got = 1'b1;
      end
      if (!got) check("b_valid_timeout", valids_b, 3);
    end
    enable_b = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("b_latch_pulse_overlap", overlap_b, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/famicom_pad_reader.md
Name: famicom_pad_reader

Overview:
- Initiator end of the Famicom/NES serial controller protocol.
- Generates famicom_latch and famicom_pulse, then shifts in famicom_data serially.
- Delivers a decoded, active-high button byte with a one-cycle valid strobe.
- Sits inside daphne_shell between the external pad pin, or the top-level keyboard/joystick emulator, and the game I/O logic.

Parameters:
- HALF_PERIOD, 6: clk_sys cycles per pulse-low and per pulse-high phase. Must be >=4.
- LATCH_CYCLES, 12: cycles latch is held high per frame. Must be >=2.
- POLL_INTERVAL, 1666667: cycles between frame starts (60 Hz at 100 MHz).
- NUM_BITS, 8: serial bits captured per frame.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allows new polling frames to start.
- famicom_data  in  1  serial data from the pad. Active-low: 0 = pressed.
- famicom_latch  out  1  parallel-load strobe to the pad.
- famicom_pulse  out  1  shift clock to the pad. The pad shifts on the rising edge.
- buttons  out  NUM_BITS  decoded buttons, active-high. Bit k = k-th serial bit, inverted.
- buttons_valid  out  1  one-cycle strobe; buttons updated this cycle.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset values: famicom_latch=0, famicom_pulse=0, buttons=0, buttons_valid=0, busy=0, state=IDLE, shift register=0, poll counter marked expired.
- Reset mid-frame aborts the frame:
  - latch and pulse are low in the cycle after reset is sampled;
  - no valid strobe is issued;
  - buttons are cleared.
- famicom_data passes through a 2-flop synchronizer. Only the synchronized value is sampled.
- States:
  - IDLE: wait until enable=1 and the poll counter has expired, then go to LATCH. The poll counter is reloaded at LATCH entry.
  - LATCH: latch=1 for LATCH_CYCLES cycles, then go to LOW with bit index k=0.
  - LOW: pulse=0 for HALF_PERIOD cycles. In the last cycle, shift the synchronized data into position k.
    - If k=NUM_BITS-1, go to DONE.
    - Otherwise go to HIGH.
  - HIGH: pulse=1 for HALF_PERIOD cycles, then k<=k+1 and go to LOW.
  - DONE: one cycle. buttons<=~shift and buttons_valid=1, then go to IDLE.
- Frame timing, with cycle 0 = first latch-high cycle:
  - sample for bit k at cycle LATCH_CYCLES+(2k+1)*HALF_PERIOD-1;
  - buttons_valid at cycle LATCH_CYCLES+(2*NUM_BITS-1)*HALF_PERIOD (102 with defaults).
  - Exactly NUM_BITS-1 pulse rising edges per frame.
- Latch and pulse are never high together. Both outputs are registered and glitch-free.
- Poll counter:
  - Decrements every cycle, saturating at 0. Sized for POLL_INTERVAL (32 bits).
  - Expiry is checked only in IDLE.
  - If POLL_INTERVAL is shorter than the frame length, the next frame starts on the cycle after DONE, giving exactly one IDLE cycle between frames.
- enable deasserted mid-frame: the current frame completes and delivers valid; no new frame starts. On re-enable with the counter expired, the frame starts next cycle.
- buttons hold their value between frames. The shift register is cleared at LATCH entry.

Decomposition:
- famicom_pkg holds:
  - state enum (IDLE, LATCH, LOW, HIGH, DONE);
  - default constants FAMICOM_HALF_PERIOD, FAMICOM_LATCH_CYCLES, FAMICOM_POLL_60HZ_100M;
  - the NUM_BITS default.
- Sub-module famicom_phase_timer: loadable down-counter with load, value and done outputs. It is shared by LATCH/LOW/HIGH phase timing.
- The poll counter stays inline.

Test Plan:
- Pad model loaded with raw 8'b1111_1110 (A pressed) -> buttons=8'h01 with valid at cycle 102 after the latch rise; latch high exactly 12 cycles.
- Raw pad byte 8'h5A -> buttons=8'hA5; exactly 7 pulse rising edges, each phase 6 cycles; latch and pulse never high together.
- POLL_INTERVAL=200, enable held high -> latch rises every 200 cycles; one valid per frame; the pad value changed between frames is reflected in the next frame.
- enable dropped at cycle 40 of a frame -> that frame still produces valid at cycle 102; no further latch while enable=0.
- reset asserted at cycle 50 of a frame -> next cycle latch=0, pulse=0, buttons=0, no valid; after release with enable=1, a new latch starts the following cycle.
- POLL_INTERVAL=50 (shorter than the frame) -> frames back-to-back, with the latch rise 2 cycles after buttons_valid (DONE, then one IDLE cycle).
